// File: rtl/gameport_pkg.sv
// Paddle timer constants and the shared load-value clamp.
// Also used by keyboard-paddle emulation.
package gameport_pkg;

  localparam int CENTER_DEF    = 2800;
  localparam int GAIN_DEF      = 22;
  localparam int CLAMP_HI_DEF  = 5590;
  localparam int MAX_COUNT_DEF = 5650;

  function automatic int clamp_load(
    input int v,
    input int hi,
    input int full
  );
    if (v < 0) begin
      return 0;
    end else if (v >= hi) begin
      return full;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/gameport_paddles_if.sv
// Joystick-side bus into the paddle timers.
// The MiSTer input side drives it; the paddle block receives it.
interface gameport_paddles_if #(
  parameter int NUM_CH   = 4,
  parameter int AN_WIDTH = 8
);

  logic [NUM_CH*AN_WIDTH-1:0] ANALOG;
  logic [NUM_CH-1:0]          DIG_MODE;
  logic [NUM_CH-1:0]          DIG_LO;
  logic [NUM_CH-1:0]          DIG_HI;

  modport master (
    output ANALOG,
    output DIG_MODE,
    output DIG_LO,
    output DIG_HI
  );

  modport slave (
    input ANALOG,
    input DIG_MODE,
    input DIG_LO,
    input DIG_HI
  );

endinterface

// File: rtl/paddle_channel.sv
// One 558-style one-shot: load mux, clamp and down-counter.
// Counts only on the shared CLK_2M tick.
module paddle_channel
  import gameport_pkg::*;
#(
  parameter int AN_WIDTH  = 8,
  parameter int CNT_WIDTH = 13,
  parameter int CENTER    = CENTER_DEF,
  parameter int GAIN      = GAIN_DEF,
  parameter int CLAMP_HI  = CLAMP_HI_DEF,
  parameter int MAX_COUNT = MAX_COUNT_DEF
) (
  input  logic                CLK_14M,
  input  logic                RESET_N,
  input  logic                tick,
  input  logic                load_en,
  input  logic [AN_WIDTH-1:0] analog,
  input  logic                dig_mode,
  input  logic                dig_lo,
  input  logic                dig_hi,
  output logic                pdl_out,
  output logic                active
);

  logic signed [AN_WIDTH-1:0] an_s;
  logic [CNT_WIDTH-1:0]       cnt;
  logic [CNT_WIDTH-1:0]       load;
  int                         v;

  assign an_s   = analog;
  assign active = (cnt != '0);

  always_comb begin
    v    = CENTER + GAIN * int'(an_s);
    load = CNT_WIDTH'(clamp_load(v, CLAMP_HI, MAX_COUNT));
    if (dig_mode) begin
      unique case (1'b1)
        (dig_lo & ~dig_hi): load = '0;
        (dig_hi & ~dig_lo): load = CNT_WIDTH'(MAX_COUNT);
        default:            load = CNT_WIDTH'(CENTER);
      endcase
    end
  end

  // Output lags the counter by one tick so a load of C gives C high ticks.
  always_ff @(posedge CLK_14M) begin
    if (!RESET_N) begin
      cnt     <= '0;
      pdl_out <= 1'b0;
    end else if (tick) begin
      pdl_out <= active;
      if (load_en) begin
        cnt <= load;
      end else if (active) begin
        cnt <= cnt - CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/gameport_paddles.sv
// Apple II game-port paddle timers: tick detect, strobe capture
// and NUM_CH independent one-shot channels.
module gameport_paddles
  import gameport_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int AN_WIDTH  = 8,
  parameter int CNT_WIDTH = 13,
  parameter int CENTER    = CENTER_DEF,
  parameter int GAIN      = GAIN_DEF,
  parameter int CLAMP_HI  = CLAMP_HI_DEF,
  parameter int MAX_COUNT = MAX_COUNT_DEF
) (
  input  logic              CLK_14M,
  input  logic              RESET_N,
  input  logic              CLK_2M,
  input  logic              PDL_STROBE,
  gameport_paddles_if.slave joy,
  output logic [NUM_CH-1:0] PDL_OUT,
  output logic              BUSY
);

  logic              clk2m_d;
  logic              strobe_pend;
  logic              tick;
  logic              load_en;
  logic [NUM_CH-1:0] active;

  assign tick    = CLK_2M & ~clk2m_d;
  assign load_en = tick & (strobe_pend | PDL_STROBE);
  assign BUSY    = |active;

  // A strobe seen on the tick cycle itself is consumed there.
  always_ff @(posedge CLK_14M) begin
    if (!RESET_N) begin
      clk2m_d     <= 1'b0;
      strobe_pend <= 1'b0;
    end else begin
      clk2m_d <= CLK_2M;
      if (tick) begin
        strobe_pend <= 1'b0;
      end else if (PDL_STROBE) begin
        strobe_pend <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    paddle_channel #(
      .AN_WIDTH (AN_WIDTH),
      .CNT_WIDTH(CNT_WIDTH),
      .CENTER   (CENTER),
      .GAIN     (GAIN),
      .CLAMP_HI (CLAMP_HI),
      .MAX_COUNT(MAX_COUNT)
    ) u_ch (
      .CLK_14M (CLK_14M),
      .RESET_N (RESET_N),
      .tick    (tick),
      .load_en (load_en),
      .analog  (joy.ANALOG[i*AN_WIDTH +: AN_WIDTH]),
      .dig_mode(joy.DIG_MODE[i]),
      .dig_lo  (joy.DIG_LO[i]),
      .dig_hi  (joy.DIG_HI[i]),
      .pdl_out (PDL_OUT[i]),
      .active  (active[i])
    );
  end

endmodule

// File: tb/tb_gameport_paddles.sv
// Bench for gameport_paddles: default 4-channel instance plus a
// 2-channel, 10-bit, gain-5 instance, checked tick by tick.
module tb_gameport_paddles;

  logic       CLK_14M = 1'b0;
  logic       RESET_N = 1'b0;
  logic       CLK_2M = 1'b0;
  logic       PDL_STROBE = 1'b0;
  logic [3:0] out_a;
  logic       busy_a;
  logic [1:0] out_b;
  logic       busy_b;

  gameport_paddles_if #(.NUM_CH(4), .AN_WIDTH(8))  ja ();
  gameport_paddles_if #(.NUM_CH(2), .AN_WIDTH(10)) jb ();

  gameport_paddles dut_a (
    .CLK_14M   (CLK_14M),
    .RESET_N   (RESET_N),
    .CLK_2M    (CLK_2M),
    .PDL_STROBE(PDL_STROBE),
    .joy       (ja),
    .PDL_OUT   (out_a),
    .BUSY      (busy_a)
  );

  gameport_paddles #(
    .NUM_CH  (2),
    .AN_WIDTH(10),
    .GAIN    (5)
  ) dut_b (
    .CLK_14M   (CLK_14M),
    .RESET_N   (RESET_N),
    .CLK_2M    (CLK_2M),
    .PDL_STROBE(PDL_STROBE),
    .joy       (jb),
    .PDL_OUT   (out_b),
    .BUSY      (busy_b)
  );

  always #5 CLK_14M = ~CLK_14M;

  int n_chk = 0;
  int n_fail = 0;
  int an[6];
  bit dm[6];
  bit lo[6];
  bit hi[6];
  int ld_t[6];
  int ld_c[6];
  int hc[6];
  int tn = 0;
  bit pend = 1'b0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at tick %0d: got %0d expected %0d",
               tag, tn, got, exp);
    end
  endtask

  function automatic int ref_load(input int ch);
    int g;
    int v;
    g = (ch < 4) ? 22 : 5;
    if (dm[ch]) begin
      if (lo[ch] && !hi[ch]) return 0;
      if (hi[ch] && !lo[ch]) return 5650;
      return 2800;
    end
    v = 2800 + g * an[ch];
    if (v < 0) return 0;
    if (v >= 5590) return 5650;
    return v;
  endfunction

  function automatic int rem(input int ch, input int m);
    int r;
    r = ld_c[ch] - (m - ld_t[ch]);
    return (r > 0) ? r : 0;
  endfunction

  task automatic drive();
    for (int c = 0; c < 4; c++) begin
      ja.ANALOG[c*8 +: 8] = 8'(an[c]);
      ja.DIG_MODE[c] = dm[c];
      ja.DIG_LO[c]   = lo[c];
      ja.DIG_HI[c]   = hi[c];
    end
    for (int c = 0; c < 2; c++) begin
      jb.ANALOG[c*10 +: 10] = 10'(an[c+4]);
      jb.DIG_MODE[c] = dm[c+4];
      jb.DIG_LO[c]   = lo[c+4];
      jb.DIG_HI[c]   = hi[c+4];
    end
  endtask

  // Entered and left at a falling edge; one tick per call, 3 cycles.
  task automatic tick_period(input bit stb_t, input bit stb_g);
    logic [3:0] ea;
    logic [1:0] eb;
    bit         ba;
    bit         bb;
    drive();
    CLK_2M     = 1'b1;
    PDL_STROBE = stb_t;
    @(posedge CLK_14M);
    tn++;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) ea[c] = (rem(c, tn - 1) != 0);
      else       eb[c-4] = (rem(c, tn - 1) != 0);
    end
    if (stb_t || pend) begin
      for (int c = 0; c < 6; c++) begin
        ld_t[c] = tn;
        ld_c[c] = ref_load(c);
      end
    end
    pend = 1'b0;
    ba = 1'b0;
    bb = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rem(c, tn) != 0) begin
        if (c < 4) ba = 1'b1;
        else       bb = 1'b1;
      end
    end
    @(negedge CLK_14M);
    check("pdl_a", 32'(out_a), 32'(ea));
    check("busy_a", 32'(busy_a), 32'(ba));
    check("pdl_b", 32'(out_b), 32'(eb));
    check("busy_b", 32'(busy_b), 32'(bb));
    for (int c = 0; c < 4; c++) hc[c] += int'(out_a[c]);
    for (int c = 0; c < 2; c++) hc[c+4] += int'(out_b[c]);
    CLK_2M     = 1'b0;
    PDL_STROBE = stb_g;
    if (stb_g) pend = 1'b1;
    @(negedge CLK_14M);
    @(negedge CLK_14M);
    PDL_STROBE = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick_period(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    @(negedge CLK_14M);
    check("rst_pdl_a", 32'(out_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_pdl_b", 32'(out_b), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    RESET_N = 1'b1;
    for (int c = 0; c < 6; c++) begin
      ld_t[c] = tn;
      ld_c[c] = 0;
    end
    pend = 1'b0;
  endtask

  task automatic clr_hc();
    for (int c = 0; c < 6; c++) hc[c] = 0;
  endtask

  task automatic rand_inputs();
    for (int c = 0; c < 6; c++) begin
      if (c < 4) an[c] = int'($urandom_range(0, 255)) - 128;
      else       an[c] = int'($urandom_range(0, 1023)) - 512;
      dm[c] = ($urandom_range(0, 3) == 0);
      lo[c] = $urandom_range(0, 1) != 0;
      hi[c] = $urandom_range(0, 1) != 0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int c = 0; c < 6; c++) begin
      an[c] = 0; dm[c] = 0; lo[c] = 0; hi[c] = 0;
      ld_t[c] = 0; ld_c[c] = 0; hc[c] = 0;
    end
    drive();
    repeat (3) @(negedge CLK_14M);
    check("init_pdl_a", 32'(out_a), 32'd0);
    check("init_busy_a", 32'(busy_a), 32'd0);
    check("init_pdl_b", 32'(out_b), 32'd0);
    check("init_busy_b", 32'(busy_b), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK_14M);

    // Centre, clamp-high and clamp-low analog loads
    an[0] = 0; an[1] = 127; an[2] = -128;
    an[3] = int'($urandom_range(0, 255)) - 128;
    an[4] = 511;
    an[5] = int'($urandom_range(0, 1023)) - 512;
    clr_hc();
    tick_period(1'b1, 1'b0);
    run(5660);
    check("len_ch0", hc[0], 2800);
    check("len_ch1", hc[1], 5650);
    check("len_ch2", hc[2], 0);
    check("len_b_ch0", hc[4], 5355);

    // Gap strobe with analog changed before the consuming tick
    rand_inputs();
    for (int c = 0; c < 6; c++) dm[c] = 0;
    tick_period(1'b0, 1'b1);
    an[0] = 50;
    clr_hc();
    tick_period(1'b0, 1'b0);
    run(3905);
    check("len_late_an", hc[0], 3900);

    // Digital overrides, retrigger, held strobe, reset mid-pulse
    dm[0] = 0; an[0] = -10;
    dm[1] = 1; lo[1] = 1; hi[1] = 0;
    dm[2] = 1; lo[2] = 0; hi[2] = 1;
    dm[3] = 1; lo[3] = 1; hi[3] = 1;
    tick_period(1'b1, 1'b0);
    run(100);
    tick_period(1'b1, 1'b0);
    repeat (3) tick_period(1'b1, 1'b1);
    run(1800);
    do_reset();
    clr_hc();
    run(50);
    check("post_rst_hi", hc[0] + hc[2] + hc[3] + hc[4], 0);

    // Pending strobe discarded by reset
    tick_period(1'b0, 1'b1);
    do_reset();
    clr_hc();
    run(20);
    check("rst_drops_pend", hc[0] + hc[2] + hc[3], 0);

    // Randomised traffic
    for (int it = 0; it < 25; it++) begin
      rand_inputs();
      tick_period($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
      for (int k = 0; k < int'($urandom_range(0, 250)); k++) begin
        if ($urandom_range(0, 15) == 0) an[0] = int'($urandom_range(0, 255)) - 128;
        tick_period($urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0);
      end
      if ($urandom_range(0, 9) == 0) do_reset();
    end
    run(5700);
    check("drain_busy_a", 32'(busy_a), 32'd0);
    check("drain_busy_b", 32'(busy_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
